slot_game_controller: RTL

Game-side consumer of the three 3-bit reel values produced by rng_system. It manages a credit balance, charges a bet per spin, and drives the RNG's button_press input for a fixed spin window. It then samples the settled reels, classifies the outcome and credits the payout. It sits between the player inputs (coin, start) and rng_system, and feeds the display/money logic.

---
 rtl/slot_game_controller_if.sv | 47 ++++
 rtl/slot_game_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/slot_game_controller_if.sv
// -----------------------------------------------------------------------------
// slot_game_controller_if
// Groups the player inputs, reel values and game outputs of the slot game
// controller into a single bundle.
//
// Signals:
//   coin_in    : one-cycle pulse, adds a coin's worth of credits
//   start      : one-cycle pulse, requests a spin
//   rng1..rng3 : 3-bit reel values from the RNG
//   spin_req   : drives the RNG button_press input
//   busy       : high whenever the controller is not idle
//   credits    : current credit balance
//   win_valid  : one-cycle pulse when a spin result is final
//   win_amount : payout of the last spin (held)
//   win_class  : outcome of the last spin, 0 none / 1 pair / 2 triple / 3 jackpot
//   reject     : one-cycle pulse when a start is refused for lack of credits
//
// Modports:
//   master : player/RNG side, drives inputs and observes results
//   slave  : controller side
// -----------------------------------------------------------------------------
interface slot_game_controller_if #(
    parameter int CREDIT_W = 16
) ();
    logic                coin_in;
    logic                start;
    logic [2:0]          rng1;
    logic [2:0]          rng2;
    logic [2:0]          rng3;
    logic                spin_req;
    logic                busy;
    logic [CREDIT_W-1:0] credits;
    logic                win_valid;
    logic [CREDIT_W-1:0] win_amount;
    logic [1:0]          win_class;
    logic                reject;

    modport master (
        output coin_in, start, rng1, rng2, rng3,
        input  spin_req, busy, credits, win_valid, win_amount, win_class, reject
    );

    modport slave (
        input  coin_in, start, rng1, rng2, rng3,
        output spin_req, busy, credits, win_valid, win_amount, win_class, reject
    );
endinterface

// File: rtl/slot_game_controller.sv
// -----------------------------------------------------------------------------
// slot_game_controller
// Game-side consumer of the three reel values from the RNG. Keeps a saturating
// credit balance, charges a bet per accepted spin, holds spin_req high for a
// fixed window, waits for the reels to settle, samples and classifies them and
// credits the payout.
//
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : slot_game_controller_if.slave (player inputs, reels, results)
//
// All outputs are registered. Credit arithmetic is unsigned and saturates at
// the all-ones value of CREDIT_W bits.
// -----------------------------------------------------------------------------
module slot_game_controller #(
    parameter int CREDIT_W      = 16,
    parameter int COIN_VALUE    = 25,
    parameter int BET           = 10,
    parameter int SPIN_CYCLES   = 50,
    parameter int SETTLE_CYCLES = 2,
    parameter int PAY_PAIR      = 50,
    parameter int PAY_TRIPLE    = 500,
    parameter int PAY_JACKPOT   = 5000
) (
    input  logic                    clk,
    input  logic                    reset,
    slot_game_controller_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPIN   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_EVAL   = 3'd3,
        ST_PAYOUT = 3'd4
    } state_t;

    // The shared counter only ever reaches (longest window - 1).
    localparam int CNT_MAX = (SPIN_CYCLES > SETTLE_CYCLES) ? SPIN_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    // Two guard bits: balance + coin + payout never exceeds 3x the credit range.
    localparam int EXT_W   = CREDIT_W + 2;

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};

    // Outcome classification of three reel values.
    function automatic logic [1:0] classify(input logic [2:0] a,
                                            input logic [2:0] b,
                                            input logic [2:0] c);
        logic [1:0] cls;
        cls = 2'd0;
        if ((a == b) && (b == c)) begin
            if (a == 3'b111) begin
                cls = 2'd3;
            end else begin
                cls = 2'd2;
            end
        end else if ((a == b) || (b == c) || (a == c)) begin
            cls = 2'd1;
        end else begin
            cls = 2'd0;
        end
        return cls;
    endfunction

    // Payout value for an outcome class.
    function automatic logic [CREDIT_W-1:0] payout_of(input logic [1:0] cls);
        logic [CREDIT_W-1:0] amt;
        case (cls)
            2'd1:    amt = CREDIT_W'(PAY_PAIR);
            2'd2:    amt = CREDIT_W'(PAY_TRIPLE);
            2'd3:    amt = CREDIT_W'(PAY_JACKPOT);
            default: amt = {CREDIT_W{1'b0}};
        endcase
        return amt;
    endfunction

    // Clamp an extended-width credit result into the credit range.
    function automatic logic [CREDIT_W-1:0] sat_credit(input logic [EXT_W-1:0] v);
        logic [CREDIT_W-1:0] r;
        if (v > {2'b00, CREDIT_MAX}) begin
            r = CREDIT_MAX;
        end else begin
            r = v[CREDIT_W-1:0];
        end
        return r;
    endfunction

    state_t              state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [CREDIT_W-1:0] credits_q,    credits_d;
    logic                spin_req_q,   spin_req_d;
    logic                win_valid_q,  win_valid_d;
    logic [CREDIT_W-1:0] win_amount_q, win_amount_d;
    logic [1:0]          win_class_q,  win_class_d;
    logic                reject_q,     reject_d;
    logic [1:0]          eval_class_q, eval_class_d;

    logic [EXT_W-1:0]    coin_add_s;
    logic [EXT_W-1:0]    pay_add_s;
    logic [EXT_W-1:0]    bet_sub_s;

    // Next-state, output and credit computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        spin_req_d   = spin_req_q;
        win_valid_d  = 1'b0;
        reject_d     = 1'b0;
        win_amount_d = win_amount_q;
        win_class_d  = win_class_q;
        eval_class_d = eval_class_q;
        pay_add_s    = {EXT_W{1'b0}};
        bet_sub_s    = {EXT_W{1'b0}};

        // Coins are accepted in every state.
        if (bus.coin_in) begin
            coin_add_s = EXT_W'(COIN_VALUE);
        end else begin
            coin_add_s = {EXT_W{1'b0}};
        end

        case (state_q)
            ST_IDLE: begin
                spin_req_d = 1'b0;
                if (bus.start) begin
                    // Affordability uses the balance before this cycle's coin.
                    if (credits_q >= CREDIT_W'(BET)) begin
                        bet_sub_s  = EXT_W'(BET);
                        state_d    = ST_SPIN;
                        cnt_d      = {CNT_W{1'b0}};
                        spin_req_d = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SPIN: begin
                // spin_req was raised on entry, so drop it after SPIN_CYCLES cycles.
                if (cnt_q == CNT_W'(SPIN_CYCLES - 1)) begin
                    state_d    = ST_SETTLE;
                    cnt_d      = {CNT_W{1'b0}};
                    spin_req_d = 1'b0;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    spin_req_d = 1'b1;
                end
            end

            ST_SETTLE: begin
                spin_req_d = 1'b0;
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_EVAL;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_EVAL: begin
                // Only place where the reel inputs are looked at.
                eval_class_d = classify(bus.rng1, bus.rng2, bus.rng3);
                state_d      = ST_PAYOUT;
            end

            ST_PAYOUT: begin
                pay_add_s    = {2'b00, payout_of(eval_class_q)};
                win_amount_d = payout_of(eval_class_q);
                win_class_d  = eval_class_q;
                win_valid_d  = 1'b1;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d    = ST_IDLE;
                cnt_d      = {CNT_W{1'b0}};
                spin_req_d = 1'b0;
            end
        endcase

        // Bet is only subtracted when credits_q >= BET, so no underflow.
        credits_d = sat_credit({2'b00, credits_q} + coin_add_s + pay_add_s - bet_sub_s);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            credits_q    <= {CREDIT_W{1'b0}};
            spin_req_q   <= 1'b0;
            win_valid_q  <= 1'b0;
            win_amount_q <= {CREDIT_W{1'b0}};
            win_class_q  <= 2'd0;
            reject_q     <= 1'b0;
            eval_class_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            credits_q    <= credits_d;
            spin_req_q   <= spin_req_d;
            win_valid_q  <= win_valid_d;
            win_amount_q <= win_amount_d;
            win_class_q  <= win_class_d;
            reject_q     <= reject_d;
            eval_class_q <= eval_class_d;
        end
    end

    assign bus.spin_req   = spin_req_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.credits    = credits_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_amount = win_amount_q;
    assign bus.win_class  = win_class_q;
    assign bus.reject     = reject_q;

endmodule
